// File: rtl/seg7_scan_controller_pkg.sv
// Shared types, segment constants and the digit-to-segment decoder used by
// the 4-digit multiplexed 7-segment display controller.
package seg7_pkg;

    // Converter phases: load operand, run 16 shift-add-3 steps, publish result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Active-low segment patterns, bit order {dp, g, f, e, d, c, b, a}.
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Number of BCD nibbles held by the converter (ten-thousands included).
    localparam int BCD_NIBBLES = 5;

    // Map one BCD digit onto its active-low segment pattern with dp off.
    // Non-decimal nibbles light nothing.
    function automatic logic [7:0] seg7_decode(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_bin2bcd16.sv
// Sequential 16-bit binary to BCD converter (double dabble). One full loop
// is IDLE (load) + 16 SHIFT steps + COMMIT = 18 cycles, repeating forever.
// The bcd/overflow outputs change only in COMMIT, so a consumer never sees
// digits from two different operands mixed together.
module bin2bcd16
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [15:0] bcd,
    output logic        overflow
);

    conv_state_t state;
    logic [15:0] bin_sr;      // binary operand, shifted out MSB first
    logic [19:0] bcd_acc;     // five-nibble BCD accumulator
    logic [3:0]  step_cnt;    // SHIFT step index 0..15
    logic [19:0] bcd_adj;     // accumulator after the add-3 correction

    // Add 3 to every nibble that is 5 or more so the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
        logic [19:0] res;
        res = acc;
        for (int n = 0; n < BCD_NIBBLES; n++) begin
            if (res[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = res[n*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Correction applied to the accumulator before each shift.
    always_comb begin
        bcd_adj = dabble_adjust(bcd_acc);
    end

    // Converter FSM; reset abandons any conversion in flight and clears the
    // published result. The operand registers need no reset since IDLE
    // always reloads them before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_cnt <= 4'd0;
            bcd      <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bin_sr   <= value;
                    bcd_acc  <= 20'h00000;
                    step_cnt <= 4'd0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bcd_acc  <= (bcd_adj << 1) | {19'd0, bin_sr[15]};
                    bin_sr   <= bin_sr << 1;
                    step_cnt <= step_cnt + 4'd1;
                    if (step_cnt == 4'd15) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    bcd      <= bcd_acc[15:0];
                    overflow <= (bcd_acc[19:16] != 4'd0);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// 4-digit multiplexed 7-segment display driver. Converts a binary value to
// BCD, then lights one digit at a time for REFRESH_DIV clocks each, cycling
// units -> tens -> hundreds -> thousands. Anodes and segments are active-low
// and registered together so they always switch on the same edge.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100_000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [15:0] bcd,
    output logic        overflow
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;
    logic [3:0]       digit;
    logic [3:0]       lead_zero;   // digit n and every higher digit are zero
    logic             slot_blank;
    logic             dp_n;
    logic [7:0]       digit_pat;
    logic [3:0]       an_next;
    logic [7:0]       seg_next;

    bin2bcd16 u_bin2bcd16 (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .bcd      (bcd),
        .overflow (overflow)
    );

    // Dwell timer per digit; the scan index advances on each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Pick the nibble for the current slot and work out which leading
    // digits are zero. The units digit is never treated as leading.
    always_comb begin
        case (scan_idx)
            2'd0:    digit = bcd[3:0];
            2'd1:    digit = bcd[7:4];
            2'd2:    digit = bcd[11:8];
            default: digit = bcd[15:12];
        endcase
        lead_zero[3] = (bcd[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        slot_blank   = BLANK_LEADING && !overflow && lead_zero[scan_idx];
    end

    // Next anode/segment image: dashes on overflow, dark slot when blanked,
    // otherwise the decoded digit with its decimal point.
    always_comb begin
        dp_n      = ~dp_en[scan_idx];
        digit_pat = seg7_decode(digit);
        an_next   = ~(4'b0001 << scan_idx);
        seg_next  = {digit_pat[7] & dp_n, digit_pat[6:0]};
        if (overflow) begin
            seg_next = {SEG_DASH[7] & dp_n, SEG_DASH[6:0]};
        end else if (slot_blank) begin
            an_next  = 4'hF;
            seg_next = SEG_OFF;
        end
    end

    // Pin registers; display is dark while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller with REFRESH_DIV=4. Two instances share
// stimulus: one with leading-zero blanking, one without. A decimal-arithmetic
// reference tracks which value is committed and what every slot should show.
module tb_seg7_scan_controller;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_en;

    logic [3:0]  an_b, an_f;
    logic [7:0]  seg_b, seg_f;
    logic [15:0] bcd_b, bcd_f;
    logic        ov_b, ov_f;

    int checks   = 0;
    int failures = 0;
    int cyc       = 0;   // rising edges since reset released
    int sampled   = 0;   // operand captured at the start of the current loop
    int committed = 0;   // operand whose digits are on bcd

    logic [7:0] pat_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    seg7_scan_controller #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b1)) u_blank (
        .clk(clk), .rst(rst), .value(value), .dp_en(dp_en),
        .an(an_b), .seg(seg_b), .bcd(bcd_b), .overflow(ov_b)
    );

    seg7_scan_controller #(.REFRESH_DIV(RDIV), .BLANK_LEADING(1'b0)) u_full (
        .clk(clk), .rst(rst), .value(value), .dp_en(dp_en),
        .an(an_f), .seg(seg_f), .bcd(bcd_f), .overflow(ov_f)
    );

    function automatic logic [15:0] to_bcd(input int v);
        int w;
        w = v % 10000;
        return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit is_blank(input int v, input int slot, input bit blank_en);
        return blank_en && (v <= 9999) && (slot > 0) && (v < pow10(slot));
    endfunction

    function automatic logic [3:0] exp_an(input int v, input int slot, input bit blank_en);
        logic [3:0] a;
        if (is_blank(v, slot, blank_en)) return 4'hF;
        a = 4'hF;
        a[slot] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int slot, input bit blank_en,
                                           input logic [3:0] dp);
        logic [7:0] s;
        if (v > 9999) begin
            s = 8'hBF;
        end else if (is_blank(v, slot, blank_en)) begin
            return 8'hFF;
        end else begin
            s = pat_tbl[(v / pow10(slot)) % 10];
        end
        if (dp[slot]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: capture inputs seen at the edge, advance the reference,
    // then compare every output of both instances.
    task automatic tick();
        logic       r;
        logic [15:0] v;
        logic [3:0] d;
        int         prev;
        int         slot;
        @(posedge clk);
        r = rst;
        v = value;
        d = dp_en;
        #1;
        if (r) begin
            cyc       = 0;
            sampled   = 0;
            committed = 0;
            chk("rst_an_b",  {12'd0, an_b},  16'h000F);
            chk("rst_seg_b", {8'd0, seg_b},  16'h00FF);
            chk("rst_bcd_b", bcd_b,          16'h0000);
            chk("rst_ov_b",  {15'd0, ov_b},  16'h0000);
            chk("rst_an_f",  {12'd0, an_f},  16'h000F);
            chk("rst_seg_f", {8'd0, seg_f},  16'h00FF);
            chk("rst_bcd_f", bcd_f,          16'h0000);
        end else begin
            cyc++;
            prev = committed;
            if (cyc % 18 == 1) sampled = int'(v);
            if (cyc % 18 == 0) committed = sampled;
            slot = ((cyc - 1) / RDIV) % 4;
            chk("bcd_b", bcd_b, to_bcd(committed));
            chk("ov_b",  {15'd0, ov_b}, {15'd0, committed > 9999});
            chk("bcd_f", bcd_f, to_bcd(committed));
            chk("ov_f",  {15'd0, ov_f}, {15'd0, committed > 9999});
            chk("an_b",  {12'd0, an_b},  {12'd0, exp_an(prev, slot, 1'b1)});
            chk("seg_b", {8'd0, seg_b},  {8'd0, exp_seg(prev, slot, 1'b1, d)});
            chk("an_f",  {12'd0, an_f},  {12'd0, exp_an(prev, slot, 1'b0)});
            chk("seg_f", {8'd0, seg_f},  {8'd0, exp_seg(prev, slot, 1'b0, d)});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the converter loop reaches the given phase (1 = IDLE).
    task automatic to_phase(input int ph);
        int guard;
        guard = 0;
        while ((cyc % 18) != ph && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        assert (guard < 40)
        else begin
            failures++;
            $error("FAIL phase_wait observed=%0d expected=%0d", cyc % 18, ph);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        value = 16'd1234;
        dp_en = 4'b0000;
        run(3);

        // Release with 1234: first commit on the 18th edge, units slot first.
        rst = 1'b0;
        tick();
        chk("first_an", {12'd0, an_b}, 16'h000E);
        run(16);
        chk("pre_commit", bcd_b, 16'h0000);
        tick();
        chk("first_commit", bcd_b, 16'h1234);
        run(40);

        // Leading-zero blanking, then zero shows only the units digit.
        value = 16'd7;
        run(60);
        value = 16'd0;
        run(60);

        // Overflow dashes, then back to 9999.
        value = 16'd10000;
        run(60);
        chk("ovf_flag", {15'd0, ov_b}, 16'h0001);
        value = 16'd9999;
        run(40);
        chk("ovf_clear", {15'd0, ov_b}, 16'h0000);

        // Change during SHIFT: next commit keeps 1234, the one after is 4321.
        value = 16'd1234;
        run(40);
        to_phase(5);
        value = 16'd4321;
        to_phase(0);
        chk("shift_ignore", bcd_b, 16'h1234);
        tick();
        to_phase(0);
        chk("shift_next", bcd_b, 16'h4321);

        // Decimal point on the hundreds digit.
        value = 16'd1234;
        dp_en = 4'b0100;
        run(60);

        // Reset mid-scan and mid-SHIFT.
        dp_en = 4'b0000;
        to_phase(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(40);

        // Random operands, decimal points, dwell times and occasional resets.
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 5) == 0)
                value = 16'($urandom_range(10000, 65535));
            else if ($urandom_range(0, 2) == 0)
                value = 16'($urandom_range(0, 99));
            else
                value = 16'($urandom_range(0, 9999));
            dp_en = 4'($urandom_range(0, 15));
            run($urandom_range(5, 60));
            if (it % 6 == 5) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
Drives a 4-digit multiplexed 7-segment display from a 16-bit binary value (0..9999), such as the decimal count from the counter block. It converts the binary value to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the four digits by cycling the anode enables at a programmable refresh rate. All outputs go straight to board pins; segments and anodes are active-low.

Parameters:
REFRESH_DIV, 100_000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2 or more.
BLANK_LEADING, 1, 1 = leading zeros blanked (units digit always shown); 0 = all four digits always shown.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  reset, synchronous and active-high.
value  in  16  binary number to display; sampled once per conversion.
dp_en  in  4  decimal-point enable per digit (bit0 = units digit).
an  out  4  digit anodes, active-low, one-hot-low while lit (an[0] = units).
seg  out  8  segments, active-low: seg[7]=dp, seg[6]=g ... seg[0]=a.
bcd  out  16  committed BCD value {thousands, hundreds, tens, units}, for debug.
overflow  out  1  committed value was > 9999.

Behaviour:
- Reset values: an=4'hF, seg=8'hFF, bcd=0, overflow=0. Scan index=0, refresh count=0, converter FSM=IDLE. Reset during a conversion aborts it; no partial result is committed.
- All outputs are registered.
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE, running continuously.
  - IDLE (1 cycle): capture value into the shift register; clear the 20-bit BCD accumulator.
  - SHIFT (16 cycles): each cycle, first add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1.
  - COMMIT (1 cycle): write the low 4 nibbles to bcd. Set overflow if the ten-thousands nibble != 0 (equivalent to value > 9999).
- Timing: one loop is 18 cycles. The first commit happens on the 18th cycle after rst deasserts. A change on value is shown within 36 cycles.
- bcd and overflow update only in COMMIT, so the display never shows digits from two different values. Changes to value during SHIFT are ignored until the next IDLE.
- Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances 0->1->2->3->0.
- an and seg are registered together from the scan index, so they change in the same cycle.
- Digit pattern (active-low, dp bit = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. seg[7] = ~dp_en[idx].
- Overflow: every digit shows a dash, seg=BF (dp_en still applies). No blanking.
- Leading-zero blanking (BLANK_LEADING=1, no overflow): digit idx > 0 is blank if it and all higher digits are zero.
  - A blank slot drives an=4'hF and seg=8'hFF for its whole period.
  - The dp of a blank digit is suppressed.
- BCD nibble values above 9 cannot occur; if one does, the decoder outputs FF.

Decomposition:
- Package seg7_pkg holds:
  - converter state enum {IDLE, SHIFT, COMMIT};
  - SEG_OFF=8'hFF and SEG_DASH=8'hBF;
  - a digit-to-segment function.
- Sub-module bin2bcd16 is the natural split. It contains the converter FSM and ports clk, rst, value, bcd, overflow.
- The top level holds the refresh counter, scan index, blanking logic and output registers.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset, then value=1234 -> bcd=16'h1234 on cycle 18. an steps through 1110, 1101, 1011, 0111, 4 cycles each, with seg 99, B0, A4, F9 respectively.
2. value=7, BLANK_LEADING=1 -> units slot an=1110 with seg=F8. The other three slots have an=1111 and seg=FF. With value=0 the units digit shows C0.
3. value=0, BLANK_LEADING=0 -> all four slots show seg=C0 with their anode low.
4. value=10000 -> overflow=1 and all four slots show seg=BF. Then value=9999 -> overflow=0 and all slots show 90 within 36 cycles.
5. value changes 1234->4321 mid-SHIFT -> bcd goes straight from 1234 to 4321 at a COMMIT, with no intermediate value. dp_en=4'b0100 with value=1234 -> the hundreds slot shows seg=24.
6. Assert rst mid-scan and mid-SHIFT -> next cycle an=F, seg=FF, bcd=0. After release the scan restarts at an=1110 and the first commit is 18 cycles later.
